pulse_timer_bank: RTL and testbench
===================================

# pulse_timer_bank

Parametrised bank of independent pulse-extension timers: each channel turns a single-cycle trigger into an `active` level lasting a runtime-programmable number of clock cycles. It supersedes single fixed-length extenders in the game logic, for example power-pellet frightened time, invulnerability windows and sound or flash durations. It adds per-channel retrigger modes, cancel, a global pause, an expiry strobe and a remaining-time readback. It sits between game event sources and the FSMs or draw logic that consume timed levels.

## Interface
- NUM_CH, 4, number of independent timer channels (1..32)
- CNT_W, 24, counter width per channel; maximum duration 2^CNT_W-1 cycles
- clk  in  1  system clock, all state updates on rising edge
- resetN  in  1  asynchronous, active-low reset
- pause  in  1  global freeze: counters hold, triggers and cancels still honoured
- pulse_in  in  NUM_CH  per-channel trigger, sampled each cycle (level, not edge)
- cancel  in  NUM_CH  per-channel abort
- duration_in  in  NUM_CH*CNT_W  per-channel duration in cycles; channel i occupies bits [i*CNT_W +: CNT_W]
- mode  in  2*NUM_CH  per-channel mode; channel i occupies bits [2i +: 2]
- rd_sel  in  $clog2(NUM_CH) (min 1)  channel index for readback
- active  out  NUM_CH  channel i is high while its counter is nonzero
- expired  out  NUM_CH  one-cycle strobe on natural expiry
- rd_remaining  out  CNT_W  remaining count of channel rd_sel

## Operation
- Each channel has a counter `cnt`. `active[i] = (cnt != 0)` is decoded combinationally from the registered counter.
- Modes:
  - 0 RETRIGGER: a trigger loads `cnt <= D`.
  - 1 ONESHOT: a trigger is ignored while `cnt != 0`, otherwise it loads D.
  - 2 ACCUMULATE: a trigger sets `cnt <= min(cnt + D, 2^CNT_W-1)`, computed CNT_W+1 wide and then saturated.
  - 3: reserved, behaves as RETRIGGER.
- D is `duration_in` sampled in the trigger cycle. D=0 makes the trigger a no-op: no load, no expiry, and in ACCUMULATE mode the count is unchanged.
- Per-channel priority each cycle, highest first:
  - cancel: `cnt <= 0`, no expiry strobe.
  - accepted trigger: load or accumulate; the decrement is skipped this cycle.
  - decrement: when `cnt != 0` and pause=0, `cnt <= cnt - 1`.
  - otherwise hold.
- An ignored trigger (ONESHOT while active) falls through to the decrement or hold rule.
- `expired[i]` is a registered strobe. It is set at the edge where `cnt` goes 1→0 through a decrement, and is low in every other cycle.
  - A retrigger or cancel in the cycle `cnt == 1` suppresses it.
  - Pause while `cnt == 1` delays it.
- `rd_remaining = cnt[rd_sel]` combinationally. It returns 0 when `rd_sel >= NUM_CH`.
- Changing `mode` or `duration_in` while a channel is active has no effect until the next accepted trigger.
- Channels are fully independent; simultaneous events on different channels do not interact.

## Timing
- Reset (asynchronous, any time, including mid-count): all `cnt = 0`, so `active = 0`, `expired = 0`, `rd_remaining = 0`. There is no expiry strobe on reset.
- Latency: trigger sampled at edge k gives `active` high from edge k through edge k+D, i.e. exactly D cycles without pause. `expired` is high for the cycle after edge k+D, coincident with the first cycle `active` is low.
- Each pause cycle extends the active window by one cycle.
- Cancel sampled at edge k drops `active` after edge k.
- A trigger held high continuously in RETRIGGER mode keeps `cnt = D`; `active` stays high and there is no expiry.
- A trigger held high continuously in ACCUMULATE mode saturates at 2^CNT_W-1 and stays there while the trigger remains high.

## Structure
- Package `pulse_timer_pkg`:
  - `typedef enum logic [1:0] {PT_RETRIGGER, PT_ONESHOT, PT_ACCUMULATE, PT_RSVD} pt_mode_t`
  - localparam for the saturation maximum as a function of CNT_W.
- Sub-module `pulse_timer_channel #(CNT_W)` holds one counter, the priority logic, saturation and the expired register. The top level generates NUM_CH instances, slices the flat buses and implements the readback mux.

## Test plan
- RETRIGGER, D=5, one pulse at cycle 10 → `active` high cycles 11–15, `expired` high cycle 16 only, `rd_remaining` 5,4,3,2,1,0.
- RETRIGGER, D=5, pulse at 10 and again at 13 → `active` high through cycle 18, single `expired` at 19. ONESHOT with the same stimulus → `expired` at 16, second pulse ignored.
- ACCUMULATE, CNT_W=4, D=10, pulses at 10 and 11 → cnt=10 then 15 (saturated), `active` lasts 16 cycles in total.
- Cancel at cnt=3 → `active` drops the next cycle, no `expired`. Cancel and pulse in the same cycle → cnt=0.
- Pause held 4 cycles mid-count with D=6 → `active` lasts 10 cycles, `expired` delayed by 4. A pulse arriving during pause still loads.
- resetN asserted asynchronously mid-count on all 4 channels → all outputs 0 immediately, no `expired`. D=0 pulse → no activity. rd_sel=NUM_CH with NUM_CH=3 → `rd_remaining` = 0.

Source files
------------

// File: rtl/pulse_timer_pkg.sv
// Shared types and constants for the pulse timer bank.
package pulse_timer_pkg;

    typedef enum logic [1:0] {
        PT_RETRIGGER  = 2'd0,
        PT_ONESHOT    = 2'd1,
        PT_ACCUMULATE = 2'd2,
        PT_RSVD       = 2'd3
    } pt_mode_t;

    localparam int          PT_CNT_W_DEFAULT   = 24;
    localparam logic [31:0] PT_SAT_MAX_DEFAULT = (32'd1 << PT_CNT_W_DEFAULT) - 32'd1;

    // Largest count representable in a counter of the given width.
    function automatic logic [31:0] pt_sat_max(input int cnt_w);
        return (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
    endfunction

endpackage

// File: rtl/pulse_timer_channel.sv
// One pulse-extension timer: counter, trigger/cancel/pause priority,
// accumulate saturation and the natural-expiry strobe.
module pulse_timer_channel
    import pulse_timer_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             pause,
    input  logic             pulse,
    input  logic             cancel,
    input  logic [CNT_W-1:0] duration,
    input  logic [1:0]       mode,
    output logic [CNT_W-1:0] cnt,
    output logic             active,
    output logic             expired
);

    localparam logic [CNT_W-1:0] SAT_MAX = CNT_W'(pt_sat_max(CNT_W));

    pt_mode_t         mode_e;
    logic             busy;
    logic             trig_ok;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] acc_val;

    assign mode_e  = pt_mode_t'(mode);
    assign busy    = (cnt != '0);
    assign active  = busy;
    // A zero duration, or a one-shot that is already running, ignores the trigger.
    assign trig_ok = pulse && (duration != '0) && !((mode_e == PT_ONESHOT) && busy);
    assign sum     = {1'b0, cnt} + {1'b0, duration};
    assign acc_val = sum[CNT_W] ? SAT_MAX : sum[CNT_W-1:0];

    // Counter update with priority cancel > trigger > decrement > hold.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (cancel) begin
                cnt <= '0;
            end else if (trig_ok) begin
                cnt <= (mode_e == PT_ACCUMULATE) ? acc_val : duration;
            end else if (busy && !pause) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    expired <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_timer_bank.sv
// Bank of independent pulse-extension timers with remaining-time readback.
module pulse_timer_bank
    import pulse_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24
) (
    input  logic                                       clk,
    input  logic                                       resetN,
    input  logic                                       pause,
    input  logic [NUM_CH-1:0]                          pulse_in,
    input  logic [NUM_CH-1:0]                          cancel,
    input  logic [NUM_CH*CNT_W-1:0]                    duration_in,
    input  logic [2*NUM_CH-1:0]                        mode,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
    output logic [NUM_CH-1:0]                          active,
    output logic [NUM_CH-1:0]                          expired,
    output logic [CNT_W-1:0]                           rd_remaining
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CNT_W-1:0] cnt_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .resetN   (resetN),
            .pause    (pause),
            .pulse    (pulse_in[g]),
            .cancel   (cancel[g]),
            .duration (duration_in[g*CNT_W +: CNT_W]),
            .mode     (mode[2*g +: 2]),
            .cnt      (cnt_arr[g]),
            .active   (active[g]),
            .expired  (expired[g])
        );
    end

    // Readback mux; selects beyond the last channel read as zero.
    always_comb begin
        rd_remaining = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_remaining = cnt_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_pulse_timer_bank.sv
// Directed self-checking bench for pulse_timer_bank.
module tb_pulse_timer_bank;

    logic        clk;
    logic        resetN;
    logic        pause;
    logic [3:0]  pulse_in;
    logic [3:0]  cancel;
    logic [15:0] duration_in;
    logic [7:0]  mode;
    logic [1:0]  rd_sel;
    logic [3:0]  active;
    logic [3:0]  expired;
    logic [3:0]  rd_remaining;

    logic [2:0]  pulse3;
    logic [2:0]  cancel3;
    logic [23:0] dur3;
    logic [5:0]  mode3;
    logic [1:0]  rd_sel3;
    logic [2:0]  active3;
    logic [2:0]  expired3;
    logic [7:0]  rd3;

    int errors = 0;
    int checks = 0;

    pulse_timer_bank #(.NUM_CH(4), .CNT_W(4)) dut (
        .clk(clk), .resetN(resetN), .pause(pause), .pulse_in(pulse_in),
        .cancel(cancel), .duration_in(duration_in), .mode(mode),
        .rd_sel(rd_sel), .active(active), .expired(expired),
        .rd_remaining(rd_remaining)
    );

    pulse_timer_bank #(.NUM_CH(3), .CNT_W(8)) dut3 (
        .clk(clk), .resetN(resetN), .pause(pause), .pulse_in(pulse3),
        .cancel(cancel3), .duration_in(dur3), .mode(mode3),
        .rd_sel(rd_sel3), .active(active3), .expired(expired3),
        .rd_remaining(rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Channel 0 view: remaining count, active level and expiry strobe.
    task automatic chk0(input string tag, input int rem, input bit strb);
        chk({tag, ".rem"}, 32'(rd_remaining), 32'(rem));
        chk({tag, ".act"}, 32'(active[0]), 32'(rem != 0));
        chk({tag, ".exp"}, 32'(expired[0]), 32'(strb));
    endtask

    task automatic set0(input int m, input int d);
        mode[1:0]        = 2'(m);
        duration_in[3:0] = 4'(d);
    endtask

    initial begin
        resetN = 1'b0; pause = 1'b0; pulse_in = '0; cancel = '0;
        duration_in = '0; mode = '0; rd_sel = '0;
        pulse3 = '0; cancel3 = '0; dur3 = '0; mode3 = '0; rd_sel3 = '0;

        @(negedge clk);
        chk("rst.active", 32'(active), 32'd0);
        chk("rst.expired", 32'(expired), 32'd0);
        chk("rst.rd", 32'(rd_remaining), 32'd0);
        chk("rst.active3", 32'(active3), 32'd0);
        resetN = 1'b1;
        step();

        // Retrigger mode, single pulse, D=5
        set0(0, 5); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        chk0("rt1", 5, 1'b0);
        for (int k = 4; k >= 1; k--) begin step(); chk0("rt1", k, 1'b0); end
        step(); chk0("rt1.end", 0, 1'b1);
        step(); chk0("rt1.after", 0, 1'b0);

        // Retrigger mode, second pulse three cycles later
        pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0; chk0("rt2", 5, 1'b0);
        step(); chk0("rt2", 4, 1'b0);
        step(); chk0("rt2", 3, 1'b0);
        pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0; chk0("rt2.re", 5, 1'b0);
        for (int k = 4; k >= 1; k--) begin step(); chk0("rt2", k, 1'b0); end
        step(); chk0("rt2.end", 0, 1'b1);
        step(); chk0("rt2.after", 0, 1'b0);

        // One-shot mode, same stimulus: second pulse ignored
        set0(1, 5);
        pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0; chk0("os", 5, 1'b0);
        step(); chk0("os", 4, 1'b0);
        step(); chk0("os", 3, 1'b0);
        pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0; chk0("os.ign", 2, 1'b0);
        step(); chk0("os", 1, 1'b0);
        step(); chk0("os.end", 0, 1'b1);
        step();

        // Accumulate mode, D=10 twice, saturates at 15
        set0(2, 10);
        pulse_in[0] = 1'b1; step(); chk0("acc.first", 10, 1'b0);
        step(); pulse_in[0] = 1'b0; chk0("acc.sat", 15, 1'b0);
        for (int k = 14; k >= 1; k--) begin step(); chk0("acc", k, 1'b0); end
        step(); chk0("acc.end", 0, 1'b1);
        step();

        // Accumulate with D=0 while running: count keeps decrementing
        set0(2, 5); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        set0(2, 0); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        chk0("acc.d0", 4, 1'b0);
        cancel[0] = 1'b1; step(); cancel[0] = 1'b0; chk0("acc.d0.cancel", 0, 1'b0);

        // Retrigger held high keeps the count at D
        set0(0, 3); pulse_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin step(); chk0("hold", 3, 1'b0); end
        pulse_in[0] = 1'b0;
        step(); chk0("hold", 2, 1'b0);
        step(); chk0("hold", 1, 1'b0);
        step(); chk0("hold.end", 0, 1'b1);
        step();

        // Cancel at cnt=3: no expiry
        set0(0, 5); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        step(); step(); chk0("can.pre", 3, 1'b0);
        cancel[0] = 1'b1; step(); cancel[0] = 1'b0; chk0("can", 0, 1'b0);
        step(); chk0("can.after", 0, 1'b0);

        // Cancel and pulse together while running -> zero
        pulse_in[0] = 1'b1; step();
        cancel[0] = 1'b1; step(); pulse_in[0] = 1'b0; cancel[0] = 1'b0;
        chk0("canpulse", 0, 1'b0);
        step(); chk0("canpulse.after", 0, 1'b0);

        // Retrigger at cnt=1 suppresses the strobe
        set0(0, 2); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        step(); chk0("sup.pre", 1, 1'b0);
        pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0; chk0("sup", 2, 1'b0);
        step(); chk0("sup", 1, 1'b0);
        step(); chk0("sup.end", 0, 1'b1);
        step();

        // Pause held 4 cycles mid-count, D=6 -> 10 active cycles
        set0(0, 6); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        chk0("pz", 6, 1'b0);
        step(); step(); chk0("pz", 4, 1'b0);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin step(); chk0("pz.hold", 4, 1'b0); end
        pause = 1'b0;
        for (int k = 3; k >= 1; k--) begin step(); chk0("pz", k, 1'b0); end
        step(); chk0("pz.end", 0, 1'b1);
        step();

        // Pause at cnt=1 delays the strobe; pulse during pause still loads
        set0(0, 2); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        step(); pause = 1'b1;
        step(); chk0("pz1", 1, 1'b0);
        pause = 1'b0; step(); chk0("pz1.end", 0, 1'b1);
        pause = 1'b1; set0(0, 4); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        chk0("pz.load", 4, 1'b0);
        step(); chk0("pz.load.hold", 4, 1'b0);
        pause = 1'b0; cancel[0] = 1'b1; step(); cancel[0] = 1'b0;

        // D=0 trigger does nothing
        set0(0, 0); pulse_in[0] = 1'b1; step(); pulse_in[0] = 1'b0;
        chk0("d0", 0, 1'b0);
        step(); chk("d0.exp", 32'(expired), 32'd0);

        // Independent channels and readback select
        mode = 8'b00_01_10_00;
        duration_in = {4'd0, 4'd7, 4'd3, 4'd0};
        pulse_in = 4'b0110; step(); pulse_in = '0;
        chk("ind.active", 32'(active), 32'b0110);
        rd_sel = 2'd1; #1 chk("ind.rd1", 32'(rd_remaining), 32'd3);
        rd_sel = 2'd2; #1 chk("ind.rd2", 32'(rd_remaining), 32'd7);
        step(); step(); step();
        chk("ind.exp", 32'(expired), 32'b0010);
        chk("ind.active2", 32'(active), 32'b0100);
        #1 chk("ind.rd2b", 32'(rd_remaining), 32'd4);
        rd_sel = 2'd0;
        cancel = 4'b1111; step(); cancel = '0;

        // Asynchronous reset mid-count on all channels
        duration_in = {4'd9, 4'd9, 4'd9, 4'd9}; mode = '0;
        pulse_in = 4'b1111; step(); pulse_in = '0; step();
        chk("ar.pre", 32'(active), 32'b1111);
        #2 resetN = 1'b0;
        #1;
        chk("ar.active", 32'(active), 32'd0);
        chk("ar.expired", 32'(expired), 32'd0);
        chk("ar.rd", 32'(rd_remaining), 32'd0);
        @(negedge clk); resetN = 1'b1;
        step();
        chk("ar.after.active", 32'(active), 32'd0);
        chk("ar.after.expired", 32'(expired), 32'd0);

        // Three-channel bank: out-of-range select reads zero
        dur3 = {8'd0, 8'd0, 8'd200}; pulse3 = 3'b001; step(); pulse3 = '0;
        rd_sel3 = 2'd0; #1 chk("n3.rd0", 32'(rd3), 32'd200);
        rd_sel3 = 2'd3; #1 chk("n3.rd3", 32'(rd3), 32'd0);
        chk("n3.active", 32'(active3), 32'b001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
